fb_word_writer: RTL and testbench
=================================

# fb_word_writer

Upstream stage of the 64x64 monochrome VGA display path: accepts 32-bit pixel words over a Nios II multi-cycle custom-instruction handshake (start/dataa/datab/result/done). It serialises each word into 32 single-bit writes on the write port of the 4096x1 framebuffer RAM, which the VGA scan logic reads at 25 MHz. It runs on the same 25 MHz pixel clock as the RAM.

## Interface
Parameters:
- ADDR_W, 12, framebuffer address width (4096 pixels, 64x64)
- WORD_W, 32, pixels per command word

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  25 MHz pixel clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  command strobe, one-cycle pulse
- dataa  in  32  [ADDR_W-1:0] base pixel index; [31] clear opcode (see Configuration); [30:ADDR_W] must be zero
- datab  in  32  pixel bits; bit i goes to pixel base+i
- result  out  32  completion status
- done  out  1  one-cycle completion pulse
- busy  out  1  high while a command is executing
- wraddress  out  ADDR_W  RAM write address
- data  out  1  RAM write data
- wren  out  1  RAM write enable

## Operation
- States: IDLE, WRITE, FINISH.
- IDLE: wren=0, busy=0. start=1 latches dataa/datab into internal registers, clears the bit counter (5 bits) and moves to WRITE.
- WRITE: each cycle drives wren=1, wraddress=(base+cnt) mod 2^ADDR_W, data=datab_q[cnt], then cnt+=1. After cnt=31 is issued, the block moves to FINISH.
- FINISH: done=1 for exactly one cycle, result=32 (pixels written), then IDLE.
- Address arithmetic is ADDR_W bits wide and wraps silently: base 4090 writes 4090..4095, then 0..25.
- Invalid command: dataa[30:ADDR_W]≠0, or dataa[31]=1 with clear compiled out. No RAM writes occur; the block goes IDLE→FINISH with result=32'hFFFF_FFFF.
- start while busy=1 is ignored; the latched registers stay unchanged.
- start coincident with done (FINISH cycle) is ignored. The host must issue the next start after done.
- Reset: all state returns to IDLE immediately. wren=0, done=0, busy=0, result=0, wraddress=0, data=0. A word in progress is abandoned (partial writes remain in RAM) and no done is issued.

## Timing
- Start sampled on edge E0. busy=1 from E0 to E33.
- wren=1 for exactly 32 consecutive cycles, E1..E32, bit 0 first.
- done=1 in the cycle after E33. Total latency from start to done is 34 cycles.
- Invalid command: done in the cycle after E1, latency 2 cycles, wren never asserted.
- result is registered. It is valid from the done cycle and holds until the next accepted start.
- All outputs come from flops, with no combinational path from inputs.

## Configuration
- FB_CLEAR_EN defined: dataa[31]=1 is a clear command.
  - The block writes datab[0] to all 4096 addresses 0..4095 (wren E1..E4096; the dataa base is ignored).
  - Counter widened to ADDR_W bits.
  - result=4096 on completion.
- FB_CLEAR_EN undefined: the counter is 5 bits, and dataa[31]=1 is rejected as invalid (result=32'hFFFF_FFFF).

## Test plan
- Normal write: dataa=0x40, datab=0xA5A5_0001. RAM pixels 64..95 hold the bits LSB first (pixel 64=1, pixel 65=0); wren is high for 32 cycles; done follows 34 cycles after start; result=32.
- Wrap-around: dataa=4090, datab=0xFFFF_FFFF. Addresses 4090..4095 then 0..25 are written with 1; nothing else changes.
- Start while busy: second start at E10 with dataa=0x100. Ignored; only the first word is written; one done pulse.
- Invalid: dataa=0x0000_1000. No wren; done 2 cycles after start; result=0xFFFF_FFFF.
- Reset mid-word: rst_n low at E16. wren drops asynchronously; pixels base..base+15 are written, the rest untouched; no done; the next start works normally.
- Clear (FB_CLEAR_EN defined): dataa=0x8000_0000, datab=1. All 4096 pixels read 1; result=4096. Without the macro, result=0xFFFF_FFFF and there are no writes.

Source files
------------

// File: rtl/fb_word_writer.sv
// fb_word_writer
// Takes 32-bit pixel words from a Nios II multi-cycle custom-instruction
// handshake and serialises each word into single-bit writes on the write
// port of the 4096x1 monochrome framebuffer RAM.
//
// Optional feature macro: FB_CLEAR_EN
//   defined   : dataa[31]=1 clears the whole framebuffer to datab[0]
//   undefined : dataa[31]=1 is rejected as an invalid command
//
// Output timing (start sampled on edge E0):
//   valid word : wren high after E1..E32, done high after E33, busy E0..E33
//   clear      : wren high after E1..E4096, done after E4097
//   invalid    : no wren, done high after E1
// Every output is a flop; there is no combinational input-to-output path.
module fb_word_writer #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [31:0]       dataa,
    input  logic [31:0]       datab,
    output logic [31:0]       result,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] wraddress,
    output logic              data,
    output logic              wren
);

    // Index width into the pixel word.
    localparam int IDX_W = $clog2(WORD_W);

`ifdef FB_CLEAR_EN
    // A clear walks every framebuffer address, so the counter spans it.
    localparam int CNT_W = ADDR_W;
`else
    localparam int CNT_W = IDX_W;
`endif

    localparam logic [31:0] RES_WORD  = 32'(WORD_W);
    localparam logic [31:0] RES_CLEAR = 32'(2 ** ADDR_W);
    localparam logic [31:0] RES_ERROR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Command decode: the bits between the pixel index and the opcode bit
    // are reserved and must be zero; the opcode bit needs the clear build.
    function automatic logic cmd_ok(input logic [31:0] a);
        logic upper_zero;
        upper_zero = (a[30:ADDR_W] == {(31 - ADDR_W){1'b0}});
`ifdef FB_CLEAR_EN
        return upper_zero;
`else
        return upper_zero & ~a[31];
`endif
    endfunction

    // Clear opcode as seen by this build.
    function automatic logic cmd_clear(input logic [31:0] a);
`ifdef FB_CLEAR_EN
        return a[31];
`else
        return 1'b0 & a[31];
`endif
    endfunction

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [WORD_W-1:0]   pix_q, pix_d;
    logic                clear_q, clear_d;
    logic                err_q, err_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   wraddress_q, wraddress_d;
    logic                data_q, data_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic [31:0]         result_q, result_d;

    logic [CNT_W-1:0]    last_cnt_s;
    logic [ADDR_W-1:0]   addr_s;
    logic                bit_s;

    // Per-cycle write address, data bit and terminal count for the command in flight.
    always_comb begin
        last_cnt_s = CNT_W'(WORD_W - 1);
        addr_s     = base_q + ADDR_W'(cnt_q);
        bit_s      = pix_q[cnt_q[IDX_W-1:0]];
        if (clear_q) begin
            last_cnt_s = {CNT_W{1'b1}};
            addr_s     = ADDR_W'(cnt_q);
            bit_s      = pix_q[0];
        end else begin
            last_cnt_s = CNT_W'(WORD_W - 1);
        end
    end

    // Next-state and registered-output logic of the command FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        pix_d       = pix_q;
        clear_d     = clear_q;
        err_d       = err_q;
        wren_d      = 1'b0;
        wraddress_d = wraddress_q;
        data_d      = data_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        result_d    = result_q;

        case (state_q)
            ST_IDLE: begin
                // A start overlapping the done pulse is not accepted.
                if (start && !done_q) begin
                    base_d = dataa[ADDR_W-1:0];
                    pix_d  = datab;
                    cnt_d  = {CNT_W{1'b0}};
                    busy_d = 1'b1;
                    if (cmd_ok(dataa)) begin
                        err_d   = 1'b0;
                        clear_d = cmd_clear(dataa);
                        state_d = ST_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        clear_d = 1'b0;
                        state_d = ST_FINISH;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_WRITE: begin
                wren_d      = 1'b1;
                wraddress_d = addr_s;
                data_d      = bit_s;
                cnt_d       = cnt_q + CNT_W'(1);
                if (cnt_q == last_cnt_s) begin
                    state_d = ST_FINISH;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (err_q) begin
                    result_d = RES_ERROR;
                end else if (clear_q) begin
                    result_d = RES_CLEAR;
                end else begin
                    result_d = RES_WORD;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any word in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            base_q      <= {ADDR_W{1'b0}};
            pix_q       <= {WORD_W{1'b0}};
            clear_q     <= 1'b0;
            err_q       <= 1'b0;
            wren_q      <= 1'b0;
            wraddress_q <= {ADDR_W{1'b0}};
            data_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            pix_q       <= pix_d;
            clear_q     <= clear_d;
            err_q       <= err_d;
            wren_q      <= wren_d;
            wraddress_q <= wraddress_d;
            data_q      <= data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            result_q    <= result_d;
        end
    end

    assign wren      = wren_q;
    assign wraddress = wraddress_q;
    assign data      = data_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule

// File: tb/tb_fb_word_writer.sv
// Self-checking bench for fb_word_writer: a bit-array model of the
// framebuffer plus a word-level command model decide what each command
// must write and when done/result must appear.
`timescale 1ns/1ps
module tb_fb_word_writer;

    localparam int ADDR_W = 12;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 4096;
`ifdef FB_CLEAR_EN
    localparam bit CLEAR_BUILD = 1'b1;
`else
    localparam bit CLEAR_BUILD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       dataa = 32'h0;
    logic [31:0]       datab = 32'h0;
    logic [31:0]       result;
    logic              done;
    logic              busy;
    logic [ADDR_W-1:0] wraddress;
    logic              data;
    logic              wren;

    fb_word_writer #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dataa(dataa), .datab(datab),
        .result(result), .done(done), .busy(busy), .wraddress(wraddress),
        .data(data), .wren(wren)
    );

    // 25 MHz pixel clock.
    always #20 clk = ~clk;

    // Framebuffer RAM write port, as the real RAM sees it.
    bit ram [DEPTH];
    always @(posedge clk) begin
        if (wren === 1'b1) ram[wraddress] <= data;
    end

    bit ram_ref [DEPTH];
    int vectors = 0;
    int miscompares = 0;

    // Observations collected while a command runs.
    int          obs_busy0, obs_wr_first, obs_wr_last, obs_wr_cnt;
    int          obs_done_n, obs_done_cnt, obs_busy_lo;
    logic [31:0] obs_result;

    // Reference model: what a command does to the framebuffer and its timing.
    task automatic model_cmd(input logic [31:0] a, input logic [31:0] b,
                             output int n_wr, output int done_at, output logic [31:0] res);
        bit ok;
        ok = (a[30:12] == 19'd0) && (!a[31] || CLEAR_BUILD);
        if (!ok) begin
            n_wr = 0; done_at = 1; res = 32'hFFFF_FFFF;
        end else if (a[31]) begin
            for (int i = 0; i < DEPTH; i++) ram_ref[i] = b[0];
            n_wr = DEPTH; done_at = DEPTH + 1; res = DEPTH;
        end else begin
            for (int i = 0; i < WORD_W; i++) ram_ref[(int'(a[11:0]) + i) % DEPTH] = b[i];
            n_wr = WORD_W; done_at = WORD_W + 1; res = WORD_W;
        end
    endtask

    function automatic int ram_diffs();
        int d = 0;
        for (int i = 0; i < DEPTH; i++) if (ram[i] != ram_ref[i]) d++;
        return d;
    endfunction

    // Issue one command; optionally inject a second start at cycle inject_at.
    task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b,
                             input int inject_at, input logic [31:0] inj_a, input int horizon);
        obs_wr_first = -1; obs_wr_last = -1; obs_wr_cnt = 0;
        obs_done_n = -1; obs_done_cnt = 0; obs_busy_lo = -1; obs_result = 32'h0;
        @(posedge clk); #1;
        dataa = a; datab = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dataa = $urandom; datab = $urandom;
        obs_busy0 = (busy === 1'b1) ? 1 : 0;
        for (int n = 1; n <= horizon; n++) begin
            if (n == inject_at) begin
                start = 1'b1; dataa = inj_a; datab = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (wren === 1'b1) begin
                if (obs_wr_first < 0) obs_wr_first = n;
                obs_wr_last = n; obs_wr_cnt++;
            end
            if (done === 1'b1) begin
                if (obs_done_n < 0) begin obs_done_n = n; obs_result = result; end
                obs_done_cnt++;
            end
            if (busy !== 1'b1 && obs_busy_lo < 0) obs_busy_lo = n;
        end
        start = 1'b0;
    endtask

    // Full check of one command against the model.
    task automatic test_cmd(input string name, input logic [31:0] a, input logic [31:0] b,
                            input int inject_at, input logic [31:0] inj_a);
        int nw, da, d; logic [31:0] res;
        model_cmd(a, b, nw, da, res);
        drive_cmd(a, b, inject_at == -1 ? da + 1 : inject_at, inj_a, da + 4);
        vectors++;
        if ({obs_wr_cnt, obs_wr_first, obs_wr_last} !== {nw, (nw > 0) ? 1 : -1, (nw > 0) ? nw : -1}) begin
            miscompares++;
            $display("FAIL %s wren: count/first/last got %0d/%0d/%0d expected %0d/%0d/%0d", name,
                     obs_wr_cnt, obs_wr_first, obs_wr_last, nw, (nw > 0) ? 1 : -1, (nw > 0) ? nw : -1);
        end
        vectors++;
        if ({obs_done_n, obs_done_cnt} !== {da, 1}) begin
            miscompares++;
            $display("FAIL %s done: cycle/pulses got %0d/%0d expected %0d/1", name, obs_done_n, obs_done_cnt, da);
        end
        vectors++;
        if (obs_result !== res) begin
            miscompares++;
            $display("FAIL %s result: got %h expected %h", name, obs_result, res);
        end
        vectors++;
        if ({obs_busy0, obs_busy_lo} !== {1, da}) begin
            miscompares++;
            $display("FAIL %s busy: high-at-E0/drop got %0d/%0d expected 1/%0d", name, obs_busy0, obs_busy_lo, da);
        end
        d = ram_diffs();
        vectors++;
        if (d !== 0) begin
            miscompares++;
            $display("FAIL %s ram: %0d pixels differ, expected 0", name, d);
        end
    endtask

    task automatic test_reset();
        #5;
        vectors++;
        if ({wren, done, busy, result, wraddress, data} !== {1'b0, 1'b0, 1'b0, 32'h0, 12'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got wren=%b done=%b busy=%b result=%h addr=%h data=%b expected all zero",
                     wren, done, busy, result, wraddress, data);
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic test_normal_write();
        test_cmd("normal", 32'h0000_0040, 32'hA5A5_0001, 0, 32'h0);
        vectors++;
        if ({ram[64], ram[65], ram[95]} !== {1'b1, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL normal_pixels: px64/65/95 got %b%b%b expected 101", ram[64], ram[65], ram[95]);
        end
    endtask

    task automatic test_random_words();
        for (int k = 0; k < 6; k++) begin
            test_cmd("random", {20'h0, 12'($urandom_range(0, DEPTH - 1))}, $urandom, 0, 32'h0);
        end
    endtask

    task automatic test_wrap();
        test_cmd("wrap", 32'd4090, 32'hFFFF_FFFF, 0, 32'h0);
        vectors++;
        if ({ram[4095], ram[0], ram[25]} !== 3'b111) begin
            miscompares++;
            $display("FAIL wrap_pixels: px4095/0/25 got %b%b%b expected 111", ram[4095], ram[0], ram[25]);
        end
    endtask

    // Second start at E10 must be ignored; only the first word lands.
    task automatic test_start_while_busy();
        test_cmd("busy_start", 32'h0000_0300, $urandom, 10, 32'h0000_0100);
    endtask

    // A start during the done cycle must not launch a command.
    task automatic test_start_on_done();
        test_cmd("start_on_done", 32'h0000_0500, $urandom, -1, 32'h0000_0200);
    endtask

    task automatic test_invalid();
        test_cmd("invalid_1000", 32'h0000_1000, $urandom, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            test_cmd("invalid_rand", {1'b0, 19'($urandom_range(1, 524287)), 12'($urandom)}, $urandom, 0, 32'h0);
        end
    endtask

    // Reset after the 16th pixel has reached the RAM; the rest of the word is lost.
    task automatic test_reset_mid_word();
        logic [31:0] b; int base, d, stray;
        b = $urandom; base = 1000;
        for (int i = 0; i < 16; i++) ram_ref[base + i] = b[i];
        @(posedge clk); #1;
        dataa = base; datab = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({wren, done, busy, result, wraddress, data} !== {1'b0, 1'b0, 1'b0, 32'h0, 12'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got wren=%b done=%b busy=%b result=%h addr=%h data=%b expected all zero",
                     wren, done, busy, result, wraddress, data);
        end
        repeat (2) @(posedge clk);
        #5 rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (wren === 1'b1 || done === 1'b1) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_quiet: got %0d cycles with wren/done expected 0", stray);
        end
        d = ram_diffs();
        vectors++;
        if (d !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_ram: %0d pixels differ, expected 0", d);
        end
        test_cmd("after_reset", 32'h0000_0800, $urandom, 0, 32'h0);
    endtask

    task automatic test_clear();
        test_cmd("clear", 32'h8000_0000, 32'h0000_0001, 0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_normal_write();
        test_random_words();
        test_wrap();
        test_start_while_busy();
        test_start_on_done();
        test_invalid();
        test_reset_mid_word();
        test_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
